// File: rtl/multi_sync_debounce.sv
// rtl/multi_sync_debounce.sv - multi-channel synchroniser, debounce filter and edge strobes
// Each channel: STAGES-deep sync chain, optional consecutive-cycle debounce, registered rise/fall strobes.
module multi_sync_debounce #(
    parameter int WIDTH     = 4,
    parameter int STAGES    = 2,
    parameter int DEBOUNCE  = 8,
    parameter bit FILTER_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]             sync_out;
    logic [WIDTH-1:0]             dout_q, dout_d;
    logic [WIDTH-1:0]             rise_q, rise_d;
    logic [WIDTH-1:0]             fall_q, fall_d;
    logic                         changed_q, changed_d;

    // Only sync_q[0] may go metastable; downstream logic sees the last stage only.
    always_comb begin
        sync_d   = {sync_q[STAGES-2:0], din};
        sync_out = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    generate
        if (FILTER_EN && (DEBOUNCE > 1)) begin : g_filter
            localparam int            CW       = $clog2(DEBOUNCE + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

            logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

            // Any agreement with dout discards the run; no partial credit survives.
            always_comb begin
                cnt_d  = cnt_q;
                dout_d = dout_q;
                for (int i = 0; i < WIDTH; i++) begin
                    if (sync_out[i] == dout_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        dout_d[i] = sync_out[i];
                        cnt_d[i]  = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end else begin : g_bypass
            assign dout_d = sync_out;
        end
    endgenerate

    always_comb begin
        rise_d    = dout_d & ~dout_q;
        fall_d    = dout_q & ~dout_d;
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q    <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign dout    = dout_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_multi_sync_debounce.sv
// tb/tb_multi_sync_debounce.sv - random and directed checks of filtered and bypass instances
// Reference: a din delay line feeding a DEBOUNCE-wide window; dout flips when the whole window disagrees.
module tb_multi_sync_debounce;

    localparam int P_WIDTH  = 4;
    localparam int P_STAGES = 2;
    localparam int P_DEB    = 8;
    localparam bit PARAMS_OK = (P_STAGES >= 2) && (P_DEB >= 1);

    generate
        if (!PARAMS_OK) begin : g_param_check
            initial $fatal(1, "bad parameters STAGES=%0d DEBOUNCE=%0d", P_STAGES, P_DEB);
        end
    endgenerate

    logic               clk;
    logic               reset;
    logic [P_WIDTH-1:0] din;
    logic [P_WIDTH-1:0] dout_f, rise_f, fall_f, dout_b, rise_b, fall_b;
    logic               chg_f, chg_b;

    multi_sync_debounce #(.WIDTH(P_WIDTH), .STAGES(P_STAGES), .DEBOUNCE(P_DEB), .FILTER_EN(1'b1)) u_dut_f (
        .clk(clk), .reset(reset), .din(din),
        .dout(dout_f), .rise(rise_f), .fall(fall_f), .changed(chg_f)
    );

    multi_sync_debounce #(.WIDTH(P_WIDTH), .STAGES(P_STAGES), .DEBOUNCE(P_DEB), .FILTER_EN(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .din(din),
        .dout(dout_b), .rise(rise_b), .fall(fall_b), .changed(chg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    // reference model state
    logic [P_WIDTH-1:0] pipe [P_STAGES];
    logic [P_WIDTH-1:0] hist [P_DEB];
    logic [P_WIDTH-1:0] m_dout, m_rise, m_fall, b_dout, b_rise, b_fall;
    logic               m_chg, b_chg;

    // event statistics
    int tick;
    int n_rise_f [P_WIDTH];
    int n_fall_f [P_WIDTH];
    int t_rise_f [P_WIDTH];
    int t_fall_f [P_WIDTH];
    int n_rise_b [P_WIDTH];
    int t_rise_b [P_WIDTH];
    int t_fall_b [P_WIDTH];
    int n_chg_f, n_chg_b;

    task automatic model_reset();
        for (int k = 0; k < P_STAGES; k++) pipe[k] = '0;
        for (int k = 0; k < P_DEB; k++) hist[k] = '0;
        m_dout = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
        b_dout = '0; b_rise = '0; b_fall = '0; b_chg = 1'b0;
    endtask

    task automatic model_edge();
        logic [P_WIDTH-1:0] s, nd;
        bit                 acc;
        s = pipe[P_STAGES-1];
        for (int k = P_STAGES - 1; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0] = din;
        for (int k = P_DEB - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = s;
        nd = m_dout;
        for (int i = 0; i < P_WIDTH; i++) begin
            acc = 1'b1;
            for (int j = 0; j < P_DEB; j++) if (hist[j][i] == m_dout[i]) acc = 1'b0;
            if (acc) nd[i] = ~m_dout[i];
        end
        m_rise = nd & ~m_dout;
        m_fall = m_dout & ~nd;
        m_chg  = |(m_rise | m_fall);
        m_dout = nd;
        b_rise = s & ~b_dout;
        b_fall = b_dout & ~s;
        b_chg  = |(b_rise | b_fall);
        b_dout = s;
    endtask

    task automatic clr_stats();
        for (int i = 0; i < P_WIDTH; i++) begin
            n_rise_f[i] = 0; n_fall_f[i] = 0; t_rise_f[i] = 0; t_fall_f[i] = 0;
            n_rise_b[i] = 0; t_rise_b[i] = 0; t_fall_b[i] = 0;
        end
        n_chg_f = 0;
        n_chg_b = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_dout"}, {dout_f, dout_b}, '0);
        chk({tag, "_strb"}, {rise_f, fall_f, rise_b, fall_b, chg_f, chg_b}, '0);
    endtask

    // Called at a negedge; drives din, advances one clock, compares, returns at the next negedge.
    task automatic step(input logic [P_WIDTH-1:0] d);
        din = d;
        @(posedge clk);
        model_edge();
        #1;
        chk("dout_f", dout_f, m_dout);
        chk("rise_f", rise_f, m_rise);
        chk("fall_f", fall_f, m_fall);
        chk("chg_f", chg_f, m_chg);
        chk("dout_b", dout_b, b_dout);
        chk("rise_b", rise_b, b_rise);
        chk("fall_b", fall_b, b_fall);
        chk("chg_b", chg_b, b_chg);
        tick++;
        for (int i = 0; i < P_WIDTH; i++) begin
            if (rise_f[i]) begin n_rise_f[i]++; t_rise_f[i] = tick; end
            if (fall_f[i]) begin n_fall_f[i]++; t_fall_f[i] = tick; end
            if (rise_b[i]) begin n_rise_b[i]++; t_rise_b[i] = tick; end
            if (fall_b[i]) t_fall_b[i] = tick;
        end
        if (chg_f) n_chg_f++;
        if (chg_b) n_chg_b++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        #1;
        model_reset();
        check_zero("rst_async");
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic hold(input logic [P_WIDTH-1:0] d, input int n);
        for (int c = 0; c < n; c++) step(d);
    endtask

    int t0;
    int rem [P_WIDTH];
    logic [P_WIDTH-1:0] d;

    initial begin
        reset = 1'b0;
        din   = '0;
        tick  = 0;
        model_reset();
        clr_stats();
        @(negedge clk);
        do_reset(3);

        // step on channel 0
        hold(4'b0000, 3);
        clr_stats();
        t0 = tick;
        hold(4'b0001, 15);
        chk("s1_lat_f", t_rise_f[0] - t0, 10);
        chk("s1_nrise", n_rise_f[0], 1);
        chk("s1_nfall", n_fall_f[0], 0);
        chk("s1_nchg", n_chg_f, 1);
        chk("s1_lat_b", t_rise_b[0] - t0, 3);
        hold(4'b0000, 20);

        // 7-cycle glitch rejected, 8-cycle pulse accepted
        clr_stats();
        hold(4'b0010, 7);
        hold(4'b0000, 20);
        chk("s2_rej_rise", n_rise_f[1], 0);
        chk("s2_rej_chg", n_chg_f, 0);
        clr_stats();
        t0 = tick;
        hold(4'b0010, 8);
        hold(4'b0000, 20);
        chk("s2_acc_nrise", n_rise_f[1], 1);
        chk("s2_acc_lat", t_rise_f[1] - t0, 10);
        chk("s2_fall_gap", t_fall_f[1] - t_rise_f[1], 8);

        // bounce train then steady high
        clr_stats();
        hold(4'b0100, 3); hold(4'b0000, 3); hold(4'b0100, 3); hold(4'b0000, 3);
        t0 = tick;
        hold(4'b0100, 15);
        chk("s3_nrise", n_rise_f[2], 1);
        chk("s3_lat", t_rise_f[2] - t0, 10);
        chk("s3_nfall", n_fall_f[2], 0);
        hold(4'b0000, 20);

        // simultaneous channels
        clr_stats();
        t0 = tick;
        hold(4'b1010, 15);
        chk("s4_lat1", t_rise_f[1] - t0, 10);
        chk("s4_lat3", t_rise_f[3] - t0, 10);
        chk("s4_nchg", n_chg_f, 1);
        hold(4'b0000, 20);

        // reset while channel 0 is counting
        hold(4'b0001, 5);
        do_reset(3);
        clr_stats();
        t0 = tick;
        hold(4'b0001, 14);
        chk("s5_nrise", n_rise_f[0], 1);
        chk("s5_lat", t_rise_f[0] - t0, 10);
        hold(4'b0000, 20);

        // one-cycle pulse through bypass instance
        clr_stats();
        t0 = tick;
        hold(4'b1000, 1);
        hold(4'b0000, 10);
        chk("s6_nrise_b", n_rise_b[3], 1);
        chk("s6_lat_b", t_rise_b[3] - t0, 3);
        chk("s6_gap_b", t_fall_b[3] - t_rise_b[3], 1);
        chk("s6_nchg_b", n_chg_b, 2);
        chk("s6_nrise_f", n_rise_f[3], 0);

        // random hold lengths around the debounce boundary, with one reset in the middle
        for (int i = 0; i < P_WIDTH; i++) rem[i] = 0;
        d = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < P_WIDTH; i++) begin
                if (rem[i] == 0) begin
                    d[i]   = 1'($urandom_range(0, 1));
                    rem[i] = $urandom_range(1, 12);
                end else begin
                    rem[i]--;
                end
            end
            step(d);
            if (c == 700) do_reset($urandom_range(1, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_sync_debounce.md
# multi_sync_debounce

Parametrised multi-channel input conditioner that replaces single-bit double-flop synchronisers at asynchronous input boundaries (buttons, switches, external status lines). Each channel passes through a configurable-depth synchroniser chain, an optional per-channel debounce counter, and an edge detector. It produces a clean, glitch-filtered level plus single-cycle rise and fall strobes in the `clk` domain.

## Interface
- WIDTH, 4: number of independent channels (≥1)
- STAGES, 2: synchroniser flops per channel (≥2)
- DEBOUNCE, 8: consecutive cycles a synchronised value must differ from `dout` before `dout` takes it (≥1)
- FILTER_EN, 1: 1 = debounce active; 0 = debounce bypassed, `dout` is the registered synchroniser output
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- din  in  WIDTH  asynchronous raw inputs, one bit per channel
- dout  out  WIDTH  synchronised and filtered level
- rise  out  WIDTH  one-cycle pulse when `dout[i]` goes 0→1
- fall  out  WIDTH  one-cycle pulse when `dout[i]` goes 1→0
- changed  out  1  OR of all `rise` and `fall` bits in the same cycle

## Operation
- Reset (`reset`=0, asynchronous): all synchroniser flops, debounce counters, `dout`, `rise`, `fall` and `changed` are cleared to 0. The release of reset is synchronous to `clk` at the system level.
- Synchroniser: per channel, a shift chain `s[0..STAGES-1]`. `s[0]` <= `din[i]` and `s[k]` <= `s[k-1]`. Only `s[STAGES-1]` (sync_i) is used downstream. `din` has no other fan-out.
- Debounce (FILTER_EN=1), per channel, with counter `cnt` of width $clog2(DEBOUNCE+1):
  - sync_i == `dout[i]`: `cnt` <= 0.
  - sync_i != `dout[i]` and `cnt` < DEBOUNCE-1: `cnt` <= `cnt`+1.
  - sync_i != `dout[i]` and `cnt` == DEBOUNCE-1: `dout[i]` <= sync_i, `cnt` <= 0.
  - Any return of sync_i to `dout[i]` before acceptance discards the accumulated count. No partial credit is kept.
  - DEBOUNCE=1 is equivalent to bypass.
- Bypass (FILTER_EN=0): `dout[i]` <= sync_i every cycle. No counters are instantiated.
- Edge detect: `rise[i]` <= ~`dout[i]` & next_dout[i], and `fall[i]` <= `dout[i]` & ~next_dout[i]. Both are registered, so the strobe is high in exactly the cycle in which `dout[i]` first shows its new value. `changed` is registered the same way: `changed` <= |(next rise | next fall).
- Channels are fully independent. Simultaneous transitions on several channels each produce their own strobes in the same cycle.
- `rise[i]` and `fall[i]` are never high together. A channel cannot produce strobes in two consecutive cycles when DEBOUNCE ≥ 2.

## Timing
- Edge numbering: edge 0 is the first `clk` rising edge at which a `din` change meets setup.
- sync_i reflects the change after edge STAGES-1.
- FILTER_EN=1: `dout`, `rise`/`fall` and `changed` update at edge STAGES+DEBOUNCE-1. Latency is STAGES+DEBOUNCE cycles (10 at defaults).
- FILTER_EN=0: outputs update at edge STAGES. Latency is STAGES+1 cycles (3 at defaults).
- Rejection: a synchronised pulse held for fewer than DEBOUNCE cycles is rejected with no output activity. A pulse held for exactly DEBOUNCE cycles is accepted.
- Strobe width: exactly 1 cycle.
- Reset mid-count: counts are lost and outputs read 0 immediately. After release, a `din` held at 1 is re-qualified from zero and produces a `rise` at full latency.
- Metastability: only `s[0]` may go metastable. The design requires STAGES ≥ 2, and the bench checks this with an elaboration-time assertion on STAGES and DEBOUNCE.

## Test plan
Unless stated otherwise, all scenarios use defaults WIDTH=4, STAGES=2, DEBOUNCE=8, FILTER_EN=1.
1. Reset then step: `din`=4'b0000 → 4'b0001 held → `dout`=4'b0001 after 10 cycles; `rise`=4'b0001 and `changed`=1 for exactly that one cycle; `fall`=0 throughout.
2. Glitch rejection: `din[1]` high for 7 cycles then low → `dout`, `rise` and `changed` remain 0. The same pulse held for 8 cycles → `dout[1]`=1 after 10 cycles, then `fall[1]` pulses 8 cycles after the synchronised return to 0.
3. Bounce train: `din[2]` toggles 1,0,1,0 every 3 cycles, then holds 1 → exactly one `rise[2]`, 10 cycles after the final 0→1 change, with no `fall[2]`.
4. Simultaneous channels: `din` 4'b0000 → 4'b1010 in one cycle → `rise`=4'b1010 in a single cycle and `changed`=1 once.
5. Reset mid-operation: `din[0]`=1 and assert `reset` 5 cycles later for 3 cycles → all outputs 0 during reset; after release, `rise[0]` fires 10 cycles after the first post-reset edge.
6. Bypass: FILTER_EN=0 and a 1-cycle-wide synchronised `din[3]` pulse → `dout[3]` high for 1 cycle at latency 3; `rise[3]` and `fall[3]` fire in consecutive cycles.
